// File: rtl/reg_file_mp.sv
// Byte-masked register file with two registered read ports and a sweep-to-zero clear engine.
// Read latency 1 cycle. No backpressure: writes and clr_req arriving while busy are dropped.
module reg_file_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [BE_WIDTH-1:0]   w_be,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] r_addr_a,
    output logic [DATA_WIDTH-1:0] r_data_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] r_addr_b,
    output logic [DATA_WIDTH-1:0] r_data_b,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] r_data_a_q, r_data_a_d;
    logic [DATA_WIDTH-1:0] r_data_b_q, r_data_b_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_fire;
    logic                  clearing;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_dat,
        input logic [DATA_WIDTH-1:0] new_dat,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_dat;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_dat[8*i +: 8];
            end
        end
        return res;
    endfunction

    // A read sees the cell as it will be after this edge: cleared, bypassed write, or stored.
    function automatic logic [DATA_WIDTH-1:0] read_view(
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  clr_hit,
        input logic                  wr_hit,
        input logic [DATA_WIDTH-1:0] wdat,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        if (clr_hit) begin
            res = '0;
        end else if (wr_hit) begin
            res = merge_lanes(stored, wdat, be);
        end else begin
            res = stored;
        end
        return res;
    endfunction

    assign clearing = (state_q == CLEAR);
    assign wr_fire  = wr_en && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clearing) begin
            mem_d[clr_ptr_q] = '0;
        end else if (wr_fire) begin
            mem_d[w_addr] = merge_lanes(mem_q[w_addr], w_data, w_be);
        end
    end

    always_comb begin
        r_data_a_d = r_data_a_q;
        r_data_b_d = r_data_b_q;
        if (rd_en_a) begin
            r_data_a_d = read_view(mem_q[r_addr_a],
                                   clearing && (r_addr_a == clr_ptr_q),
                                   wr_fire && (r_addr_a == w_addr),
                                   w_data, w_be);
        end
        if (rd_en_b) begin
            r_data_b_d = read_view(mem_q[r_addr_b],
                                   clearing && (r_addr_b == clr_ptr_q),
                                   wr_fire && (r_addr_b == w_addr),
                                   w_data, w_be);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b1;
            r_data_a_q <= '0;
            r_data_b_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            busy_q     <= busy_d;
            r_data_a_q <= r_data_a_d;
            r_data_b_q <= r_data_b_d;
        end
    end

    // Storage is not reset; the post-reset sweep zeroes it.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign r_data_a = r_data_a_q;
    assign r_data_b = r_data_b_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: vector table plus clear/reset corner sequences.
module tb_reg_file_mp;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int BW = DW / 8;
    localparam int NV = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [BW-1:0] w_be;
    logic          rd_en_a;
    logic [AW-1:0] r_addr_a;
    logic [DW-1:0] r_data_a;
    logic          rd_en_b;
    logic [AW-1:0] r_addr_b;
    logic [DW-1:0] r_data_b;
    logic          clr_req;
    logic          busy;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_be     (w_be),
        .rd_en_a  (rd_en_a),
        .r_addr_a (r_addr_a),
        .r_data_a (r_data_a),
        .rd_en_b  (rd_en_b),
        .r_addr_b (r_addr_b),
        .r_data_b (r_data_b),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [BW-1:0] wbe;
        logic          a_en;
        logic [AW-1:0] ra;
        logic [DW-1:0] ea;
        logic          b_en;
        logic [AW-1:0] rb;
        logic [DW-1:0] eb;
    } vec_t;

    typedef struct {
        logic          port_b;
        logic [DW-1:0] exp_dat;
    } sb_t;

    vec_t vecs [NV];
    sb_t  sb_q [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp_v);
    endtask

    function automatic vec_t nop();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic clr);
        wr_en    = v.wr;
        w_addr   = v.wa;
        w_data   = v.wd;
        w_be     = v.wbe;
        rd_en_a  = v.a_en;
        r_addr_a = v.ra;
        rd_en_b  = v.b_en;
        r_addr_b = v.rb;
        clr_req  = clr;
        if (v.a_en) sb_q.push_back('{1'b0, v.ea});
        if (v.b_en) sb_q.push_back('{1'b1, v.eb});
    endtask

    task automatic step(input string tag, input logic exp_busy);
        sb_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.port_b) chk({tag, "_rd_b"}, r_data_b, e.exp_dat);
            else          chk({tag, "_rd_a"}, r_data_a, e.exp_dat);
        end
        chk({tag, "_busy"}, {15'b0, busy}, {15'b0, exp_busy});
    endtask

    // Drive one cycle: write, read A, read B, clr_req, expected busy after the edge.
    task automatic cyc(input string tag,
                       input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [BW-1:0] wbe,
                       input logic a_en, input logic [AW-1:0] ra, input logic [DW-1:0] ea,
                       input logic b_en, input logic [AW-1:0] rb, input logic [DW-1:0] eb,
                       input logic clr, input logic exp_busy);
        vec_t v;
        v = '{wr, wa, wd, wbe, a_en, ra, ea, b_en, rb, eb};
        drive(v, clr);
        step(tag, exp_busy);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h0000};
        vecs[1]  = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd2, 16'h0000, 1'b1, 2'd3, 16'h0000};
        vecs[2]  = '{1'b1, 2'd2, 16'hA5C3, 2'b11, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000};
        vecs[3]  = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd2, 16'hA5C3, 1'b0, 2'd0, 16'h0000};
        vecs[4]  = '{1'b1, 2'd1, 16'h1234, 2'b11, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000};
        vecs[5]  = '{1'b1, 2'd1, 16'hFFFF, 2'b01, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h12FF};
        vecs[6]  = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd1, 16'h12FF, 1'b1, 2'd1, 16'h12FF};
        vecs[7]  = '{1'b1, 2'd0, 16'hBEEF, 2'b10, 1'b1, 2'd0, 16'hBE00, 1'b0, 2'd0, 16'h0000};
        vecs[8]  = '{1'b1, 2'd2, 16'h5555, 2'b00, 1'b1, 2'd2, 16'hA5C3, 1'b0, 2'd0, 16'h0000};
        vecs[9]  = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd2, 16'hA5C3, 1'b1, 2'd0, 16'hBE00};
        vecs[10] = '{1'b1, 2'd3, 16'h00CD, 2'b11, 1'b1, 2'd3, 16'h00CD, 1'b1, 2'd3, 16'h00CD};
        vecs[11] = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd3, 16'h00CD, 1'b1, 2'd1, 16'h12FF};

        reset_n = 1'b0;
        drive(nop(), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r_data_a", r_data_a, 16'h0000);
        chk("rst_r_data_b", r_data_b, 16'h0000);
        chk("rst_busy", {15'b0, busy}, 16'h0001);

        // Sweep after reset release: busy for four cycles.
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(nop(), 1'b0);
            step($sformatf("init_sweep%0d", i), i < 3);
        end

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i], 1'b0);
            step($sformatf("vec%0d", i), 1'b0);
        end

        // Disabled read ports hold while entry 3 is rewritten.
        cyc("hold",      1'b1, 2'd3, 16'h7777, 2'b11, 1'b0, 2'd3, 16'h0, 1'b0, 2'd3, 16'h0, 1'b0, 1'b0);
        chk("hold_keep_a", r_data_a, 16'h00CD);
        chk("hold_keep_b", r_data_b, 16'h12FF);
        cyc("hold_rd",   1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd3, 16'h7777, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);

        // Fill, then clear with writes on the entry edge, mid-sweep and the exit edge.
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("fill%0d", i), 1'b1, AW'(i), 16'h1111 * DW'(i + 1), 2'b11,
                1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        end
        cyc("clr_e0", 1'b1, 2'd3, 16'h9999, 2'b11, 1'b1, 2'd3, 16'h9999, 1'b1, 2'd2, 16'h3333, 1'b1, 1'b1);
        cyc("clr_e1", 1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd0, 16'h0000, 1'b1, 2'd2, 16'h3333, 1'b0, 1'b1);
        cyc("clr_e2", 1'b1, 2'd0, 16'hDEAD, 2'b11, 1'b1, 2'd1, 16'h0000, 1'b1, 2'd0, 16'h0000, 1'b1, 1'b1);
        cyc("clr_e3", 1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd3, 16'h9999, 1'b1, 2'd2, 16'h0000, 1'b0, 1'b1);
        cyc("clr_e4", 1'b1, 2'd1, 16'hBBBB, 2'b11, 1'b1, 2'd3, 16'h0000, 1'b1, 2'd1, 16'h0000, 1'b0, 1'b0);
        cyc("clr_rd01", 1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h0000, 1'b0, 1'b0);
        cyc("clr_rd23", 1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'd2, 16'h0000, 1'b1, 2'd3, 16'h0000, 1'b0, 1'b0);

        // Reset two cycles into a clear restarts the full sweep.
        cyc("pre_rst",  1'b1, 2'd2, 16'h5A5A, 2'b11, 1'b1, 2'd2, 16'h5A5A, 1'b1, 2'd2, 16'h5A5A, 1'b0, 1'b0);
        cyc("rclr_e0",  1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1);
        cyc("rclr_e1",  1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        cyc("rclr_e2",  1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        reset_n = 1'b0;
        cyc("mid_rst",  1'b1, 2'd0, 16'hFFFF, 2'b11, 1'b1, 2'd2, 16'h0000, 1'b1, 2'd2, 16'h0000, 1'b1, 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(nop(), 1'b0);
            step($sformatf("rst_sweep%0d", i), i < 3);
        end
        cyc("post_rst", 1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'd0, 16'h0000, 1'b1, 2'd2, 16'h0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 16: entry width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 2: address bits; depth SHALL be 2**ADDR_WIDTH entries.
REQ-003 Derived BE_WIDTH SHALL be DATA_WIDTH/8 byte lanes.
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 wr_en  in  1  write request.
REQ-008 w_addr  in  ADDR_WIDTH  write address.
REQ-009 w_data  in  DATA_WIDTH  write data.
REQ-010 w_be  in  BE_WIDTH  byte enables; bit i selects w_data[8i+7:8i].
REQ-011 rd_en_a / rd_en_b  in  1  read-port A/B enables.
REQ-012 r_addr_a / r_addr_b  in  ADDR_WIDTH  read-port A/B addresses.
REQ-013 r_data_a / r_data_b  out  DATA_WIDTH  registered read data, ports A/B.
REQ-014 clr_req  in  1  request to zero all entries.
REQ-015 busy  out  1  high while the clear engine runs.

Function
REQ-016 Two states, IDLE and CLEAR; clear pointer clr_ptr is ADDR_WIDTH bits.
REQ-017 CLEAR: each cycle, entry[clr_ptr] <= 0 and clr_ptr increments.
REQ-018 CLEAR -> IDLE after writing entry 2**ADDR_WIDTH-1; clearing takes exactly 2**ADDR_WIDTH cycles.
REQ-019 IDLE -> CLEAR on the edge where clr_req=1; clr_ptr <= 0 on that edge.
REQ-020 clr_req in CLEAR is ignored; the sweep neither restarts nor extends.
REQ-021 busy SHALL be 1 exactly while state is CLEAR (registered, no combinational path from clr_req).
REQ-022 IDLE write: on the edge with wr_en=1, lanes with w_be=1 of entry[w_addr] take w_data; other lanes hold.
REQ-023 wr_en=1 with w_be=0 leaves memory unchanged.
REQ-024 wr_en in CLEAR, including the edge leaving CLEAR, is dropped.
REQ-025 wr_en on the IDLE->CLEAR edge is performed; clearing later overwrites it.
REQ-026 Reads: latency 1; on the edge with rd_en_x=1, r_data_x <= contents of entry[r_addr_x] as seen by that read.
REQ-027 rd_en_x=0: r_data_x holds its value.
REQ-028 Write-first bypass: if a write is performed that edge and w_addr==r_addr_x, enabled lanes return w_data and the rest return stored data.
REQ-029 In CLEAR, a read of r_addr_x==clr_ptr returns 0; other addresses return stored data.
REQ-030 Ports A and B are independent; the same address on both returns identical data.
REQ-031 No combinational path from any input to any output.

Reset
REQ-032 On an edge with reset_n=0: state <= CLEAR, clr_ptr <= 0, r_data_a <= 0, r_data_b <= 0, busy <= 1.
REQ-033 When reset_n=0, reset overrides all writes, reads and clr_req on that edge.
REQ-034 After reset_n rises, busy stays 1 for 2**ADDR_WIDTH edges, then 0; all entries read 0.
REQ-035 Reset asserted mid-CLEAR restarts the sweep at entry 0.

Verification (DATA_WIDTH=16, ADDR_WIDTH=2)
REQ-036 Release reset -> busy=1 for 4 cycles then 0; reading entries 0..3 on both ports returns 0x0000.
REQ-037 Write 0xA5C3, be=11, addr 2; next cycle rd_en_a=1, addr 2 -> r_data_a=0xA5C3 one edge later.
REQ-038 Entry 1=0x1234; write 0xFFFF, be=01, addr 1 while port B reads addr 1 -> r_data_b=0x12FF (bypass); later read also 0x12FF.
REQ-039 Entries hold 0x1111..0x4444; pulse clr_req -> busy=1 for 4 cycles; wr_en mid-sweep dropped; then all entries read 0x0000.
REQ-040 rd_en_a=1 addr 3, then rd_en_a=0 while entry 3 is rewritten -> r_data_a keeps its old value.
REQ-041 Assert reset_n=0 two cycles into a clear -> r_data_a/b=0; after release busy=1 for 4 more cycles.
